// File: rtl/module_branch_unit.sv
// Branch/jump unit: forms BEQ/BNE/J/JAL/JR targets, waits out the single
// delay slot, then issues one PC load. All outputs are registered.
module module_branch_unit #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 br_valid,
   input  logic [2:0]           br_type,
   input  logic [WORD_SIZE-1:0] pc_in,
   input  logic [15:0]          imm16,
   input  logic [25:0]          jidx,
   input  logic [WORD_SIZE-1:0] rs_val,
   input  logic                 zero_fg,
   output logic                 wr_en,
   output logic [WORD_SIZE-1:0] addr,
   output logic                 link_en,
   output logic [WORD_SIZE-1:0] link_addr,
   output logic                 busy,
   output logic                 misalign,
   output logic                 slot_err
);

   localparam logic [2:0] BR_BEQ = 3'd0;
   localparam logic [2:0] BR_BNE = 3'd1;
   localparam logic [2:0] BR_J   = 3'd2;
   localparam logic [2:0] BR_JAL = 3'd3;
   localparam logic [2:0] BR_JR  = 3'd4;

   typedef enum logic [1:0] {IDLE, SLOT, REDIRECT} state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] target_q, target_d;
   logic                 wr_en_q, wr_en_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic                 link_en_q, link_en_d;
   logic [WORD_SIZE-1:0] link_addr_q, link_addr_d;
   logic                 busy_q, busy_d;
   logic                 misalign_q, misalign_d;
   logic                 slot_err_q, slot_err_d;

   logic [WORD_SIZE-1:0] seqPc;
   logic [WORD_SIZE-1:0] brTarget;
   logic [WORD_SIZE-1:0] jTarget;
   logic                 taken;
   logic [WORD_SIZE-1:0] newTarget;

   assign seqPc    = pc_in + WORD_SIZE'(4);
   assign brTarget = seqPc + {{(WORD_SIZE-18){imm16[15]}}, imm16, 2'b00};
   assign jTarget  = {seqPc[WORD_SIZE-1:28], jidx, 2'b00};

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      wr_en_d     = 1'b0;
      addr_d      = addr_q;
      link_en_d   = 1'b0;
      link_addr_d = link_addr_q;
      misalign_d  = 1'b0;
      slot_err_d  = 1'b0;
      taken       = 1'b0;
      newTarget   = target_q;

      case (state_q)
         IDLE: begin
            if (br_valid) begin
               case (br_type)
                  BR_BEQ: begin
                     taken     = zero_fg;
                     newTarget = brTarget;
                  end
                  BR_BNE: begin
                     taken     = ~zero_fg;
                     newTarget = brTarget;
                  end
                  BR_J: begin
                     taken     = 1'b1;
                     newTarget = jTarget;
                  end
                  BR_JAL: begin
                     taken       = 1'b1;
                     newTarget   = jTarget;
                     link_en_d   = 1'b1;
                     link_addr_d = pc_in + WORD_SIZE'(8);
                  end
                  BR_JR: begin
                     taken      = (rs_val[1:0] == 2'b00);
                     misalign_d = (rs_val[1:0] != 2'b00);
                     newTarget  = rs_val;
                  end
                  default: taken = 1'b0;
               endcase
               if (taken) begin
                  state_d  = SLOT;
                  target_d = newTarget;
               end
            end
         end
         SLOT: begin
            // Delay slot fetched this cycle; load the PC on the next one.
            state_d    = REDIRECT;
            wr_en_d    = 1'b1;
            addr_d     = target_q;
            slot_err_d = br_valid;
         end
         REDIRECT: begin
            state_d    = IDLE;
            slot_err_d = br_valid;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         target_q    <= '0;
         wr_en_q     <= 1'b0;
         addr_q      <= '0;
         link_en_q   <= 1'b0;
         link_addr_q <= '0;
         busy_q      <= 1'b0;
         misalign_q  <= 1'b0;
         slot_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         wr_en_q     <= wr_en_d;
         addr_q      <= addr_d;
         link_en_q   <= link_en_d;
         link_addr_q <= link_addr_d;
         busy_q      <= busy_d;
         misalign_q  <= misalign_d;
         slot_err_q  <= slot_err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign addr      = addr_q;
   assign link_en   = link_en_q;
   assign link_addr = link_addr_q;
   assign busy      = busy_q;
   assign misalign  = misalign_q;
   assign slot_err  = slot_err_q;

endmodule

// File: tb/tb_module_branch_unit.sv
// Bench for module_branch_unit: directed literal cases followed by random
// traffic checked every cycle against a cycle-scheduled event model.
module tb_module_branch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        br_valid = 1'b0;
   logic [2:0]  br_type = '0;
   logic [31:0] pc_in = '0;
   logic [15:0] imm16 = '0;
   logic [25:0] jidx = '0;
   logic [31:0] rs_val = '0;
   logic        zero_fg = 1'b0;

   logic        wr_en;
   logic [31:0] addr;
   logic        link_en;
   logic [31:0] link_addr;
   logic        busy;
   logic        misalign;
   logic        slot_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   module_branch_unit #(.WORD_SIZE(32)) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
      .pc_in(pc_in), .imm16(imm16), .jidx(jidx), .rs_val(rs_val),
      .zero_fg(zero_fg), .wr_en(wr_en), .addr(addr), .link_en(link_en),
      .link_addr(link_addr), .busy(busy), .misalign(misalign),
      .slot_err(slot_err)
   );

   always #5 clk = ~clk;

   // Cycle index advances at each rising edge; inputs for cycle c are
   // driven just after that edge and outputs are sampled on the falling edge.
   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [31:0] pc,
                                input logic [15:0] imm, input logic [25:0] ji,
                                input logic [31:0] rs, input logic z);
      @(posedge clk);
      #1;
      br_valid = v;
      br_type  = t;
      pc_in    = pc;
      imm16    = imm;
      jidx     = ji;
      rs_val   = rs;
      zero_fg  = z;
   endtask

   task automatic stepIdle();
      @(posedge clk);
      #1;
      br_valid = 1'b0;
      @(negedge clk);
   endtask

   // Event model: each accepted request books its effects into the future
   // cycles where they must appear; addr/link_addr keep the last booked value.
   localparam int DEPTH = 8192;
   bit          busyAt[DEPTH];
   bit          wrAt[DEPTH];
   bit          linkEnAt[DEPTH];
   bit          misAt[DEPTH];
   bit          slotAt[DEPTH];
   bit          setAddr[DEPTH];
   bit          setLink[DEPTH];
   logic [31:0] addrVal[DEPTH];
   logic [31:0] linkVal[DEPTH];
   logic [31:0] holdAddr = '0;
   logic [31:0] holdLink = '0;
   int          busyUntil = -1;

   function automatic logic [31:0] branchTarget(input logic [31:0] pc, input logic [15:0] imm);
      int off;
      off = int'($signed(imm)) * 4;
      return pc + 32'd4 + 32'(off);
   endfunction

   function automatic logic [31:0] jumpTarget(input logic [31:0] pc, input logic [25:0] ji);
      return ((pc + 32'd4) & 32'hF000_0000) | (32'(ji) * 32'd4);
   endfunction

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < DEPTH - 4) begin
         if (setAddr[cyc]) holdAddr = addrVal[cyc];
         if (setLink[cyc]) holdLink = linkVal[cyc];
         checkOutput("model wr_en", 32'(wr_en), 32'(wrAt[cyc]));
         checkOutput("model addr", addr, holdAddr);
         checkOutput("model busy", 32'(busy), 32'(busyAt[cyc]));
         checkOutput("model link_en", 32'(link_en), 32'(linkEnAt[cyc]));
         checkOutput("model link_addr", link_addr, holdLink);
         checkOutput("model misalign", 32'(misalign), 32'(misAt[cyc]));
         checkOutput("model slot_err", 32'(slot_err), 32'(slotAt[cyc]));
      end
      if (cyc < DEPTH - 4) begin
         if (reset) begin
            for (int k = 1; k <= 3; k++) begin
               busyAt[cyc+k] = 0; wrAt[cyc+k] = 0; linkEnAt[cyc+k] = 0;
               misAt[cyc+k] = 0; slotAt[cyc+k] = 0; setAddr[cyc+k] = 0; setLink[cyc+k] = 0;
            end
            setAddr[cyc+1] = 1; addrVal[cyc+1] = '0;
            setLink[cyc+1] = 1; linkVal[cyc+1] = '0;
            busyUntil = cyc;
         end else if (br_valid) begin
            if (cyc <= busyUntil) begin
               slotAt[cyc+1] = 1;
            end else begin
               bit          tk;
               logic [31:0] tgt;
               tk  = 0;
               tgt = '0;
               case (br_type)
                  3'd0: begin tk = zero_fg;  tgt = branchTarget(pc_in, imm16); end
                  3'd1: begin tk = !zero_fg; tgt = branchTarget(pc_in, imm16); end
                  3'd2: begin tk = 1;        tgt = jumpTarget(pc_in, jidx); end
                  3'd3: begin
                     tk = 1;
                     tgt = jumpTarget(pc_in, jidx);
                     linkEnAt[cyc+1] = 1;
                     setLink[cyc+1] = 1;
                     linkVal[cyc+1] = pc_in + 32'd8;
                  end
                  3'd4: begin
                     tgt = rs_val;
                     if (rs_val % 4 == 0) tk = 1;
                     else misAt[cyc+1] = 1;
                  end
                  default: tk = 0;
               endcase
               if (tk) begin
                  busyAt[cyc+1] = 1;
                  busyAt[cyc+2] = 1;
                  wrAt[cyc+2] = 1;
                  setAddr[cyc+2] = 1;
                  addrVal[cyc+2] = tgt;
                  busyUntil = cyc + 2;
               end
            end
         end
      end
   end

   initial begin
      // Reset held through cycles 0 and 1, released in cycle 2.
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset wr_en", 32'(wr_en), 32'd0);
      checkOutput("reset addr", addr, 32'd0);
      for (int i = 0; i < 4; i++) begin
         stepIdle();
         checkOutput("idle busy", 32'(busy), 32'd0);
         checkOutput("idle flags", 32'({wr_en, link_en, misalign, slot_err}), 32'd0);
      end

      // BEQ taken
      applyStimulus(1, 3'd0, 32'h100, 16'h0004, '0, '0, 1);
      stepIdle();
      checkOutput("beq busy N+1", 32'(busy), 32'd1);
      checkOutput("beq wr_en N+1", 32'(wr_en), 32'd0);
      stepIdle();
      checkOutput("beq wr_en N+2", 32'(wr_en), 32'd1);
      checkOutput("beq addr N+2", addr, 32'h114);
      stepIdle();
      checkOutput("beq busy N+3", 32'(busy), 32'd0);
      checkOutput("beq wr_en N+3", 32'(wr_en), 32'd0);

      // BEQ not taken
      applyStimulus(1, 3'd0, 32'h100, 16'h0004, '0, '0, 0);
      stepIdle();
      checkOutput("beq nt busy", 32'(busy), 32'd0);
      stepIdle();
      checkOutput("beq nt wr_en", 32'(wr_en), 32'd0);

      // BNE negative offset and wrap
      applyStimulus(1, 3'd1, 32'h200, 16'hFFFE, '0, '0, 0);
      stepIdle(); stepIdle();
      checkOutput("bne neg addr", addr, 32'h1FC);
      checkOutput("bne neg wr_en", 32'(wr_en), 32'd1);
      stepIdle();
      applyStimulus(1, 3'd1, 32'h0, 16'hFFFE, '0, '0, 0);
      stepIdle(); stepIdle();
      checkOutput("bne wrap addr", addr, 32'hFFFF_FFFC);
      stepIdle();

      // JAL
      applyStimulus(1, 3'd3, 32'h4000_0010, '0, 26'h0000123, '0, 0);
      stepIdle();
      checkOutput("jal link_en", 32'(link_en), 32'd1);
      checkOutput("jal link_addr", link_addr, 32'h4000_0018);
      stepIdle();
      checkOutput("jal addr", addr, 32'h4000_048C);
      checkOutput("jal wr_en", 32'(wr_en), 32'd1);
      checkOutput("jal link_en N+2", 32'(link_en), 32'd0);
      checkOutput("jal link hold", link_addr, 32'h4000_0018);
      stepIdle();

      // JR misaligned then aligned
      applyStimulus(1, 3'd4, 32'h10, '0, '0, 32'h0000_0402, 0);
      stepIdle();
      checkOutput("jr misalign", 32'(misalign), 32'd1);
      checkOutput("jr mis busy", 32'(busy), 32'd0);
      stepIdle();
      checkOutput("jr mis wr_en", 32'(wr_en), 32'd0);
      checkOutput("jr mis pulse", 32'(misalign), 32'd0);
      applyStimulus(1, 3'd4, 32'h10, '0, '0, 32'h0000_0400, 0);
      stepIdle(); stepIdle();
      checkOutput("jr addr", addr, 32'h400);
      checkOutput("jr wr_en", 32'(wr_en), 32'd1);
      stepIdle();

      // Branch in the delay slot is ignored and flagged
      applyStimulus(1, 3'd2, 32'h100, '0, 26'h80, '0, 0);
      applyStimulus(1, 3'd0, 32'h300, 16'h0004, '0, '0, 1);
      stepIdle();
      checkOutput("slot slot_err", 32'(slot_err), 32'd1);
      checkOutput("slot wr_en", 32'(wr_en), 32'd1);
      checkOutput("slot addr", addr, 32'h200);
      stepIdle();
      checkOutput("slot busy end", 32'(busy), 32'd0);
      checkOutput("slot err pulse", 32'(slot_err), 32'd0);
      stepIdle();
      checkOutput("slot no 2nd wr", 32'(wr_en), 32'd0);

      // Reset aborts a pending redirect
      applyStimulus(1, 3'd2, 32'h100, '0, 26'h90, '0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      br_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort busy N+1", 32'(busy), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort busy N+2", 32'(busy), 32'd0);
      checkOutput("abort wr_en N+2", 32'(wr_en), 32'd0);
      checkOutput("abort addr N+2", addr, 32'd0);
      stepIdle();
      checkOutput("abort wr_en N+3", 32'(wr_en), 32'd0);

      // Random traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rs;
         rs = $urandom;
         if ($urandom_range(1) == 0) rs[1:0] = 2'b00;
         applyStimulus($urandom_range(99) < 45, 3'($urandom_range(7)), $urandom & 32'hFFFF_FFFC,
                       16'($urandom), 26'($urandom), rs, 1'($urandom_range(1)));
         reset = ($urandom_range(99) == 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      br_valid = 1'b0;
      for (int i = 0; i < 5; i++) stepIdle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/module_branch_unit.md
Name: module_branch_unit

Overview:
- Control-transfer unit that drives the program counter's load interface (wr_en/addr) from decoded branch and jump requests.
- Computes targets for BEQ, BNE, J, JAL and JR, evaluates conditions using the zero flag from the status register, and sequences the single MIPS delay slot before redirecting.
- Produces the JAL link write-back, flags misaligned JR targets, and flags branches that appear in a delay slot.

Parameters:
- WORD_SIZE, 32, datapath/address width. J/JAL target formation is defined for 32 only.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- br_valid  input  1  decoded control-transfer instruction is present this cycle.
- br_type  input  3  0=BEQ, 1=BNE, 2=J, 3=JAL, 4=JR, 5-7 reserved (treated as not taken).
- pc_in  input  WORD_SIZE  address of the branch instruction.
- imm16  input  16  branch offset in words.
- jidx  input  26  J/JAL instruction index.
- rs_val  input  WORD_SIZE  JR target register value.
- zero_fg  input  1  ALU zero flag for the branch compare.
- wr_en  output  1  PC load enable.
- addr  output  WORD_SIZE  PC load address.
- link_en  output  1  register-31 write enable (JAL).
- link_addr  output  WORD_SIZE  return address.
- busy  output  1  redirect sequence in progress.
- misalign  output  1  one-cycle pulse for a misaligned JR target.
- slot_err  output  1  one-cycle pulse for br_valid while busy.

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE, and the latched target is 0.
- Reset mid-sequence drops the pending redirect: no wr_en is issued afterwards.
- States:
  - IDLE: busy=0.
  - SLOT: busy=1; the delay-slot instruction fetches normally.
  - REDIRECT: busy=1; wr_en=1 and addr=target for exactly this cycle.
  - Transitions are SLOT->REDIRECT unconditionally and REDIRECT->IDLE unconditionally.
- Taken conditions:
  - BEQ is taken if zero_fg=1.
  - BNE is taken if zero_fg=0.
  - J, JAL and JR are always taken.
- Target computation (all arithmetic modulo 2^WORD_SIZE; wrap-around is silent):
  - BEQ/BNE: pc_in + 4 + (sign-extended imm16 << 2).
  - J/JAL: {(pc_in+4)[31:28], jidx, 2'b00}.
  - JR: rs_val.
- Latency for a taken request in IDLE at cycle N:
  - The target is latched in N, and the state is SLOT in N+1.
  - The state is REDIRECT in N+2, with wr_en=1.
  - The state is IDLE in N+3.
- Not-taken branch or reserved br_type: no state change and no outputs asserted.
- JAL: link_en=1 for cycle N+1 only, with link_addr = pc_in + 8. link_addr holds its value afterwards. link_en is 0 for all other types.
- JR with rs_val[1:0] != 0:
  - Not taken; the state remains IDLE.
  - misalign=1 in cycle N+1 only.
- br_valid while busy (SLOT or REDIRECT):
  - Ignored; the sequence continues unchanged.
  - slot_err=1 in the following cycle only.
- addr holds the last target while wr_en=0. Consumers qualify addr with wr_en.
- br_valid=0: no effect on any state.

Test Plan:
- Reset: hold reset 2 cycles, then release with no requests -> all outputs 0, busy=0 for 5 cycles.
- BEQ taken: br_valid with BEQ, pc_in=0x100, imm16=0x0004, zero_fg=1 at cycle N -> busy=1 in N+1 and N+2; wr_en=1, addr=0x114 in N+2 only; busy=0 in N+3. Repeat with zero_fg=0 -> no activity.
- Negative BNE offset: pc_in=0x200, imm16=0xFFFE, zero_fg=0 -> addr=0x1FC at N+2. Repeat with pc_in=0x0, imm16=0xFFFE -> addr=0xFFFFFFFC (wrap).
- JAL: pc_in=0x40000010, jidx=0x0000123 -> link_en=1 with link_addr=0x40000018 at N+1; wr_en=1 with addr=0x4000048C at N+2.
- JR: rs_val=0x00000402 -> misalign=1 at N+1, wr_en stays 0. Then rs_val=0x400 -> addr=0x400 at N+2.
- Slot error and reset abort: J issued at N, BEQ taken at N+1 -> slot_err=1 at N+2, single wr_en at N+2 carrying the J target. Separately, assert reset at N+1 after a taken J -> wr_en never asserted, busy=0 at N+2.
